mg_pp_reduce: RTL

Pipelined partial-product generation and reduction stage for the 16x16 unsigned multiplier. It accepts operand pairs under a valid/ready handshake, forms the 256 AND-array partial products and reduces them with a Dadda tree to two 30-bit rows covering product bits [31:2]. Product bits [1:0] are resolved inside the tree. The two rows feed the `MG_CPA` 30-bit carry-propagate adder directly downstream.

---
 rtl/mg_mult_pkg.sv | 96 +++++++++
 rtl/mg_pipe_reg.sv | 29 ++
 rtl/mg_pp_reduce.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mg_mult_pkg.sv
// Shared constants, row/tree types and the Dadda level helper for the
// 16x16 partial-product reduction stage.
package mg_mult_pkg;

    localparam int MG_OP_W   = 16;
    localparam int MG_ROW_W  = 30;
    localparam int MG_PROD_W = 32;
    localparam int MG_MAXH   = 16;   // tallest column (column 15)
    localparam int MG_HW     = 5;    // width of a column height value
    localparam int MG_MID_H  = 6;    // column height after the third level
    localparam int MG_LEVELS = 6;

    localparam int MG_DADDA_H [MG_LEVELS] = '{13, 9, 6, 4, 3, 2};

    typedef struct packed {
        logic [MG_ROW_W-1:0] a;
        logic [MG_ROW_W-1:0] b;
        logic [1:0]          lo;
    } mg_rows_t;

    // Bit matrix: bits[c][0 .. h[c]-1] are live, the rest are zero.
    typedef struct packed {
        logic [MG_PROD_W-1:0][MG_MAXH-1:0] bits;
        logic [MG_PROD_W-1:0][MG_HW-1:0]   h;
    } mg_tree_t;

    function automatic int mg_pp_height(input int c);
        if (c < MG_OP_W)
            return c + 1;
        else if (c < 2*MG_OP_W-1)
            return 2*MG_OP_W - 1 - c;
        else
            return 0;
    endfunction

    // One Dadda level: reduce every column to at most d bits. Carries from
    // column c land in column c+1 of the output, so the adder count of each
    // column accounts for the carries arriving from its right neighbour.
    // Heights depend only on the matrix shape, so all loop control folds
    // to constants and only the adder bit logic remains.
    function automatic mg_tree_t mg_dadda_level(input mg_tree_t t, input int d);
        mg_tree_t           r;
        logic [MG_MAXH-1:0] cin;
        logic [MG_MAXH-1:0] cout;
        int                 ncin, ncout, idx, nout, eff, hc;
        logic               b0, b1, b2;
        r    = '0;
        cin  = '0;
        ncin = 0;
        for (int c = 0; c < MG_PROD_W; c++) begin
            cout  = '0;
            ncout = 0;
            idx   = 0;
            nout  = 0;
            hc    = int'(t.h[c]);
            eff   = hc + ncin;
            for (int k = 0; k < MG_MAXH/2; k++) begin
                if (eff > d) begin
                    b0 = t.bits[c][idx];
                    b1 = t.bits[c][idx+1];
                    if (eff == d + 1) begin
                        r.bits[c][nout] = b0 ^ b1;
                        cout[ncout]     = b0 & b1;
                        idx = idx + 2;
                        eff = eff - 1;
                    end else begin
                        b2 = t.bits[c][idx+2];
                        r.bits[c][nout] = b0 ^ b1 ^ b2;
                        cout[ncout]     = (b0 & b1) | (b0 & b2) | (b1 & b2);
                        idx = idx + 3;
                        eff = eff - 2;
                    end
                    nout  = nout + 1;
                    ncout = ncout + 1;
                end
            end
            for (int k = 0; k < MG_MAXH; k++) begin
                if (k >= idx && k < hc) begin
                    r.bits[c][nout] = t.bits[c][k];
                    nout = nout + 1;
                end
            end
            for (int k = 0; k < MG_MAXH; k++) begin
                if (k < ncin) begin
                    r.bits[c][nout] = cin[k];
                    nout = nout + 1;
                end
            end
            r.h[c] = MG_HW'(nout);
            cin    = cout;
            ncin   = ncout;
        end
        return r;
    endfunction

endpackage

// File: rtl/mg_pipe_reg.sv
// Valid/ready register slice: accepts whenever empty or draining this cycle.
module mg_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Valid follows the upstream whenever the slot is free; data only on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/mg_pp_reduce.sv
// 16x16 AND-array partial products reduced by a Dadda tree to two rows for
// the downstream 30-bit CPA. Product bits [1:0] are resolved here.
// Define MG_REDUCE_MIDREG_EN to add a register slice after the height-6 level
// (latency 3 instead of 2; row values unchanged).
module mg_pp_reduce
    import mg_mult_pkg::*;
#(
    parameter int OP_W  = 16,
    parameter int ROW_W = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_x,
    input  logic [OP_W-1:0]  in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_a,
    output logic [ROW_W-1:0] out_b,
    output logic [1:0]       out_lo
);

    if (OP_W != MG_OP_W || ROW_W != 2*OP_W-2) begin : g_bad_param
        $error("mg_pp_reduce supports only OP_W=16, ROW_W=30");
    end

    logic                   s1_valid, s1_ready;
    logic [2*MG_OP_W-1:0]   s1_data;
    logic [MG_OP_W-1:0]     s1_x, s1_y;

    mg_pipe_reg #(.W(2*MG_OP_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_y, in_x}),
        .out_valid (s1_valid),
        .out_ready (s1_ready),
        .out_data  (s1_data)
    );

    assign {s1_y, s1_x} = s1_data;

    // Column c holds pp[i][j] = x[j] & y[i] for i+j == c, packed from slot 0.
    logic [MG_PROD_W-1:0][MG_MAXH-1:0] pp_col;

    for (genvar c = 0; c < MG_PROD_W; c++) begin : g_col
        for (genvar k = 0; k < MG_MAXH; k++) begin : g_bit
            localparam int I = ((c > MG_OP_W-1) ? c - (MG_OP_W-1) : 0) + k;
            localparam int J = c - I;
            if (I < MG_OP_W && J >= 0) begin : g_pp
                assign pp_col[c][k] = s1_y[I] & s1_x[J];
            end else begin : g_zero
                assign pp_col[c][k] = 1'b0;
            end
        end
    end

    mg_tree_t tree_init;
    mg_tree_t tree_fin;
    mg_rows_t rows_d, rows_q;
    logic     st_valid, st_ready;
    logic     tree_unused;

    // Initial matrix; column 1 is resolved by a half adder before the tree.
    always_comb begin
        tree_init      = '0;
        tree_init.bits = pp_col;
        for (int c = 0; c < MG_PROD_W; c++)
            tree_init.h[c] = MG_HW'(mg_pp_height(c));
        tree_init.bits[1][0] = pp_col[1][0] ^ pp_col[1][1];
        tree_init.bits[1][1] = 1'b0;
        tree_init.bits[2][3] = pp_col[1][0] & pp_col[1][1];
        tree_init.h[1]       = MG_HW'(1);
        tree_init.h[2]       = MG_HW'(4);
    end

`ifdef MG_REDUCE_MIDREG_EN
    mg_tree_t                        tree_mid;
    logic [MG_PROD_W*MG_MID_H-1:0]   mid_d, mid_q;
    logic                            mid_unused;

    // Levels 13, 9, 6 ahead of the mid register.
    always_comb begin
        tree_mid = tree_init;
        for (int l = 0; l < 3; l++)
            tree_mid = mg_dadda_level(tree_mid, MG_DADDA_H[l]);
        mid_d = '0;
        for (int c = 0; c < MG_PROD_W; c++)
            mid_d[c*MG_MID_H +: MG_MID_H] = tree_mid.bits[c][MG_MID_H-1:0];
    end

    assign mid_unused = ^tree_mid;

    mg_pipe_reg #(.W(MG_PROD_W*MG_MID_H)) u_s1b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s1_ready),
        .in_data   (mid_d),
        .out_valid (st_valid),
        .out_ready (st_ready),
        .out_data  (mid_q)
    );

    // Levels 4, 3, 2 on the registered columns; heights are shape constants.
    always_comb begin
        tree_fin   = '0;
        tree_fin.h = tree_mid.h;
        for (int c = 0; c < MG_PROD_W; c++)
            tree_fin.bits[c][MG_MID_H-1:0] = mid_q[c*MG_MID_H +: MG_MID_H];
        for (int l = 3; l < MG_LEVELS; l++)
            tree_fin = mg_dadda_level(tree_fin, MG_DADDA_H[l]);
    end
`else
    assign st_valid = s1_valid;
    assign s1_ready = st_ready;

    // Full reduction 13, 9, 6, 4, 3, 2 in one stage.
    always_comb begin
        tree_fin = tree_init;
        for (int l = 0; l < MG_LEVELS; l++)
            tree_fin = mg_dadda_level(tree_fin, MG_DADDA_H[l]);
    end
`endif

    // Rows start at column 2; the carry out of column 31 is dropped.
    always_comb begin
        rows_d = '0;
        for (int c = 2; c < MG_PROD_W; c++) begin
            rows_d.a[c-2] = tree_fin.bits[c][0];
            rows_d.b[c-2] = tree_fin.bits[c][1];
        end
        rows_d.lo = {tree_fin.bits[1][0], tree_fin.bits[0][0]};
    end

    assign tree_unused = ^tree_fin;

    mg_pipe_reg #(.W($bits(mg_rows_t))) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (st_valid),
        .in_ready  (st_ready),
        .in_data   (rows_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (rows_q)
    );

    assign out_a  = rows_q.a;
    assign out_b  = rows_q.b;
    assign out_lo = rows_q.lo;

endmodule
